// File: rtl/inst_buf_queue_if.sv
// Fetch/decode-facing signal bundle for the instruction buffer.
// master = the pipeline side (fetch, launch select, redirect); slave = the buffer.
interface inst_buf_queue_if #(
    parameter int unsigned PTR_W = 3
);
    logic             flush;
    logic             fetch_valid;
    logic             fetch_ready;
    logic [31:0]      fetch_pc;
    logic [63:0]      fetch_inst;
    logic [1:0]       issue_cnt;
    logic             out_valid1;
    logic [31:0]      out_inst1;
    logic [31:0]      out_pc1;
    logic             out_valid2;
    logic [31:0]      out_inst2;
    logic [31:0]      out_pc2;
    logic [PTR_W:0]   count;

    modport master (
        output flush, fetch_valid, fetch_pc, fetch_inst, issue_cnt,
        input  fetch_ready, out_valid1, out_inst1, out_pc1,
        input  out_valid2, out_inst2, out_pc2, count
    );

    modport slave (
        input  flush, fetch_valid, fetch_pc, fetch_inst, issue_cnt,
        output fetch_ready, out_valid1, out_inst1, out_pc1,
        output out_valid2, out_inst2, out_pc2, count
    );
endinterface

// File: rtl/inst_buf_queue.sv
// Dual-issue instruction buffer: circular FIFO of {pc, inst} entries that
// accepts 64-bit fetch packets and presents the two oldest instructions to decode.
module inst_buf_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input logic             clk,
    input logic             rst,
    inst_buf_queue_if.slave bus
);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      mem_pc   [DEPTH];
    logic [31:0]      mem_inst [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W-1:0] wr_ptr_nxt;

    logic             ready;
    logic             push;
    logic             push_two;
    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] req_n;
    logic [CNT_W-1:0] pop_n;

    // Ready looks only at registered occupancy; same-cycle pops earn no credit.
    assign ready      = (DEPTH - 32'(count_q)) >= 32'd2;
    assign push       = bus.fetch_valid && ready && !bus.flush;
    // An 8-byte-aligned PC means both words of the packet are in the program path.
    assign push_two   = !bus.fetch_pc[2];
    assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    assign wr_ptr_nxt = wr_ptr_q + PTR_W'(1);

    // Next-state for pointers and occupancy; flush discards any push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_n   = '0;
        req_n    = (bus.issue_cnt == 2'd3) ? CNT_W'(2) : CNT_W'(bus.issue_cnt);
        pop_n    = (req_n > count_q) ? count_q : req_n;
        if (push) begin
            push_n = push_two ? CNT_W'(2) : CNT_W'(1);
        end
        if (bus.flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + push_n[PTR_W-1:0];
            rd_ptr_d = rd_ptr_q + pop_n[PTR_W-1:0];
            count_d  = count_q + push_n - pop_n;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since valid is derived from count.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            if (push_two) begin
                mem_pc[wr_ptr_q]     <= bus.fetch_pc;
                mem_inst[wr_ptr_q]   <= bus.fetch_inst[31:0];
                mem_pc[wr_ptr_nxt]   <= bus.fetch_pc + 32'd4;
                mem_inst[wr_ptr_nxt] <= bus.fetch_inst[63:32];
            end else begin
                mem_pc[wr_ptr_q]     <= bus.fetch_pc;
                mem_inst[wr_ptr_q]   <= bus.fetch_inst[63:32];
            end
        end
    end

    // Decode slots read the two oldest entries; invalid slots drive zero.
    always_comb begin
        bus.out_valid1 = count_q >= CNT_W'(1);
        bus.out_valid2 = count_q >= CNT_W'(2);
        bus.out_inst1  = '0;
        bus.out_pc1    = '0;
        bus.out_inst2  = '0;
        bus.out_pc2    = '0;
        if (bus.out_valid1) begin
            bus.out_inst1 = mem_inst[rd_ptr_q];
            bus.out_pc1   = mem_pc[rd_ptr_q];
        end
        if (bus.out_valid2) begin
            bus.out_inst2 = mem_inst[rd_ptr_nxt];
            bus.out_pc2   = mem_pc[rd_ptr_nxt];
        end
    end

    assign bus.fetch_ready = ready;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_inst_buf_queue.sv
// Bench for inst_buf_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inst_buf_queue;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [63:0] q [$];

    inst_buf_queue_if #(.PTR_W(3)) bus ();

    inst_buf_queue #(.DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a plain queue of {pc, inst}; pops come off the front, pushes go on the back.
    task automatic model_step(input logic r, input logic f, input logic fv,
                              input logic [31:0] pc, input logic [63:0] inst,
                              input logic [1:0] ic);
        int  n;
        bit  rdy;
        rdy = (DEPTH - q.size()) >= 2;
        if (!r || f) begin
            q.delete();
            return;
        end
        n = (ic == 2'd3) ? 2 : int'(ic);
        if (n > q.size()) n = q.size();
        repeat (n) void'(q.pop_front());
        if (fv && rdy) begin
            if (!pc[2]) begin
                q.push_back({pc, inst[31:0]});
                q.push_back({pc + 32'd4, inst[63:32]});
            end else begin
                q.push_back({pc, inst[63:32]});
            end
        end
    endtask

    task automatic compare(input string tag);
        int sz;
        sz = q.size();
        chk({tag, ".count"}, 64'(bus.count), 64'(sz));
        chk({tag, ".ready"}, 64'(bus.fetch_ready), 64'((DEPTH - sz) >= 2));
        chk({tag, ".valid1"}, 64'(bus.out_valid1), 64'(sz >= 1));
        chk({tag, ".valid2"}, 64'(bus.out_valid2), 64'(sz >= 2));
        chk({tag, ".pc1"}, 64'(bus.out_pc1), (sz >= 1) ? 64'(q[0][63:32]) : 64'd0);
        chk({tag, ".inst1"}, 64'(bus.out_inst1), (sz >= 1) ? 64'(q[0][31:0]) : 64'd0);
        chk({tag, ".pc2"}, 64'(bus.out_pc2), (sz >= 2) ? 64'(q[1][63:32]) : 64'd0);
        chk({tag, ".inst2"}, 64'(bus.out_inst2), (sz >= 2) ? 64'(q[1][31:0]) : 64'd0);
    endtask

    // Drive one cycle (called just after a falling edge), advance the model,
    // then check the DUT at the next falling edge.
    task automatic step(input string tag, input logic r, input logic f, input logic fv,
                        input logic [31:0] pc, input logic [63:0] inst,
                        input logic [1:0] ic);
        rst             = r;
        bus.flush       = f;
        bus.fetch_valid = fv;
        bus.fetch_pc    = pc;
        bus.fetch_inst  = inst;
        bus.issue_cnt   = ic;
        model_step(r, f, fv, pc, inst, ic);
        @(posedge clk);
        @(negedge clk);
        compare(tag);
    endtask

    initial begin
        logic [31:0] rpc;
        logic [63:0] rinst;
        total = 0;
        bad   = 0;
        rst             = 1'b0;
        bus.flush       = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_inst  = '0;
        bus.issue_cnt   = '0;
        @(negedge clk);
        step("rst0", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 2'd0);
        step("rst1", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 2'd0);
        chk("reset.count", 64'(bus.count), 64'd0);
        chk("reset.ready", 64'(bus.fetch_ready), 64'd1);
        chk("reset.valid1", 64'(bus.out_valid1), 64'd0);

        // 1: aligned packet, then dual issue.
        step("t1a", 1'b1, 1'b0, 1'b1, 32'h0000_1000, 64'h00200093_00100013, 2'd0);
        chk("t1.count", 64'(bus.count), 64'd2);
        chk("t1.pc1", 64'(bus.out_pc1), 64'h1000);
        chk("t1.inst1", 64'(bus.out_inst1), 64'h00100013);
        chk("t1.pc2", 64'(bus.out_pc2), 64'h1004);
        chk("t1.inst2", 64'(bus.out_inst2), 64'h00200093);
        chk("t1.valid2", 64'(bus.out_valid2), 64'd1);
        step("t1b", 1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 2'd2);
        chk("t1.drained", 64'(bus.count), 64'd0);
        chk("t1.v1off", 64'(bus.out_valid1), 64'd0);

        // 2: misaligned packet keeps only the high word.
        step("t2a", 1'b1, 1'b0, 1'b1, 32'h0000_2004, 64'hDEADBEEF_11111111, 2'd0);
        chk("t2.count", 64'(bus.count), 64'd1);
        chk("t2.pc1", 64'(bus.out_pc1), 64'h2004);
        chk("t2.inst1", 64'(bus.out_inst1), 64'hDEADBEEF);
        chk("t2.valid2", 64'(bus.out_valid2), 64'd0);
        chk("t2.inst2", 64'(bus.out_inst2), 64'd0);
        // 6a: over-request with one entry is clamped.
        step("t6a", 1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 2'd2);
        chk("t6.clamp", 64'(bus.count), 64'd0);

        // 3: fill to full, ignored packet, slow drain re-enables ready.
        for (int i = 0; i < 4; i++)
            step("t3fill", 1'b1, 1'b0, 1'b1, 32'h0000_3000 + 32'(i * 8),
                 {32'(i * 2 + 1), 32'(i * 2)}, 2'd0);
        chk("t3.full", 64'(bus.count), 64'd8);
        chk("t3.notready", 64'(bus.fetch_ready), 64'd0);
        step("t3ign", 1'b1, 1'b0, 1'b1, 32'h0000_9000, 64'h5555_5555_AAAA_AAAA, 2'd0);
        chk("t3.ignored", 64'(bus.count), 64'd8);
        step("t3pop1", 1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 2'd1);
        chk("t3.count7", 64'(bus.count), 64'd7);
        chk("t3.ready7", 64'(bus.fetch_ready), 64'd0);
        step("t3pop2", 1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 2'd1);
        chk("t3.ready6", 64'(bus.fetch_ready), 64'd1);
        chk("t3.head", 64'(bus.out_pc1), 64'h3008);
        step("t3flush", 1'b1, 1'b1, 1'b0, 32'h0, 64'h0, 2'd0);

        // 4: streaming across the wrap point (slot 2 from entry 0 at some point).
        for (int i = 0; i < 10; i++) begin
            step("t4", 1'b1, 1'b0, 1'b1, 32'h0000_4000 + 32'(i * 8),
                 {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)}, (i == 0) ? 2'd0 : 2'd2);
            chk("t4.pc1", 64'(bus.out_pc1), 64'(32'h0000_4000 + 32'(i * 8)));
            chk("t4.pc2", 64'(bus.out_pc2), 64'(32'h0000_4004 + 32'(i * 8)));
            chk("t4.inst2", 64'(bus.out_inst2), 64'(32'hB000_0000 + 32'(i)));
        end
        step("t4drain", 1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 2'd2);

        // 5: flush beats same-cycle push and pop.
        step("t5a", 1'b1, 1'b0, 1'b1, 32'h0000_5000, 64'h1, 2'd0);
        step("t5b", 1'b1, 1'b0, 1'b1, 32'h0000_5008, 64'h2, 2'd0);
        step("t5c", 1'b1, 1'b0, 1'b1, 32'h0000_5014, 64'h3, 2'd0);
        chk("t5.count5", 64'(bus.count), 64'd5);
        step("t5f", 1'b1, 1'b1, 1'b1, 32'h0000_7700, 64'h77, 2'd1);
        chk("t5.count0", 64'(bus.count), 64'd0);
        chk("t5.v1off", 64'(bus.out_valid1), 64'd0);
        step("t5n", 1'b1, 1'b0, 1'b1, 32'h0000_6000, 64'h66_0000_0065, 2'd0);
        chk("t5.notstale", 64'(bus.out_pc1), 64'h6000);
        chk("t5.count2", 64'(bus.count), 64'd2);

        // 6b: reset during push with flush asserted.
        step("t6r", 1'b0, 1'b1, 1'b1, 32'h0000_8000, 64'h88, 2'd0);
        chk("t6.count", 64'(bus.count), 64'd0);
        chk("t6.ready", 64'(bus.fetch_ready), 64'd1);
        chk("t6.pc1", 64'(bus.out_pc1), 64'd0);
        chk("t6.valid2", 64'(bus.out_valid2), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rpc   = {$urandom(), 2'b00};
            rinst = {$urandom(), $urandom()};
            step("rnd", ($urandom_range(0, 199) != 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0), rpc, rinst, 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_buf_queue.md
Name: inst_buf_queue

Overview:
- Instruction buffer between the fetch stage and the two decoders of the dual-issue pipeline. It takes the place of the IF/ID pipeline register.
- Accepts 64-bit fetch packets of up to two instructions, each tagged with its PC, into a circular FIFO.
- Presents the two oldest instructions to DECODE_1 and DECODE_2, and retires 0, 1 or 2 of them per cycle as the launch-select logic directs.
- A flush input empties the buffer on branch redirect.

Parameters:
- DEPTH, 8, number of single-instruction entries; power of 2, minimum 4.
- PTR_W, log2(DEPTH) = 3, read/write pointer width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- flush  in  1  discard all entries; branch redirect.
- fetch_valid  in  1  fetch packet valid this cycle.
- fetch_ready  out  1  buffer can accept a packet.
- fetch_pc  in  32  PC of the first valid instruction in the packet.
- fetch_inst  in  64  [31:0] = word at 8-byte-aligned addr; [63:32] = word at addr+4.
- issue_cnt  in  2  instructions consumed by decode this cycle (0/1/2; 3 treated as 2).
- out_valid1  out  1  slot 1 (oldest) holds an instruction.
- out_inst1  out  32  oldest instruction.
- out_pc1  out  32  PC of oldest instruction.
- out_valid2  out  1  slot 2 (second oldest) holds an instruction.
- out_inst2  out  32  second-oldest instruction.
- out_pc2  out  32  PC of second-oldest instruction.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH entries of {pc[31:0], inst[31:0]}. Registers wr_ptr and rd_ptr (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits).
- Reset (rst=0 at a rising edge): wr_ptr=0, rd_ptr=0, count=0. Entry contents are don't-care. Reset overrides flush, push and pop.
- Outputs after reset: fetch_ready=1, out_valid1=0, out_valid2=0, out_inst*/out_pc* = 0, count=0.
- fetch_ready = (DEPTH - count) >= 2. It is combinational from the registered count only and does not credit same-cycle pops.
- Push happens when fetch_valid && fetch_ready && !flush.
  - fetch_pc[2]=0: push 2 entries. First {fetch_pc, fetch_inst[31:0]}, then {fetch_pc+4, fetch_inst[63:32]}, in that order.
  - fetch_pc[2]=1: push 1 entry, {fetch_pc, fetch_inst[63:32]}; the low word is dropped.
  - fetch_pc[1:0] is ignored.
  - fetch_valid while fetch_ready=0: the packet is ignored and state is unchanged. Fetch must hold the packet.
- Pop: pop_n = min(issue_cnt clamped to 2, count). rd_ptr advances by pop_n. Over-request is clamped silently, with no error.
- Simultaneous push and pop: count_next = count + push_n - pop_n. Pops read the pre-edge head; pushes write at the pre-edge wr_ptr.
- Output slots:
  - Slot 1 = entry[rd_ptr]; slot 2 = entry[rd_ptr+1 mod DEPTH].
  - These are combinational reads of registered state.
  - out_valid1 = count>=1; out_valid2 = count>=2.
  - When a slot's valid is 0, its inst/pc outputs are forced to 0.
- Latency: a packet pushed at edge N is visible on the outputs after edge N, i.e. in cycle N+1. There is no write-to-read bypass.
- Ordering: program order is preserved across wrap-around. Slot 2 is always younger than slot 1, including when rd_ptr = DEPTH-1 (slot 2 reads entry 0).
- Flush (rst=1, flush=1): at the edge, rd_ptr <= wr_ptr and count <= 0.
  - Same-cycle push and pop are discarded.
  - Outputs are invalid from the next cycle.
  - fetch_ready is unaffected in the flush cycle itself.
- Reset mid-operation (including with fetch_valid=1) empties the buffer; no packet is accepted on that edge.
- Invariant: count <= DEPTH at all times. Overflow is impossible because fetch_ready requires >= 2 free entries.

Test Plan:
1. Reset, then push pc=0x0000_1000, inst=0x00200093_00100013 -> one cycle later count=2; out_pc1=0x1000/out_inst1=0x00100013; out_pc2=0x1004/out_inst2=0x00200093; both valid. Then issue_cnt=2 -> count=0, both valid=0.
2. Misaligned push, pc=0x0000_2004, inst high word=0xDEADBEEF -> count=1; out_pc1=0x2004, out_inst1=0xDEADBEEF; out_valid2=0, out_inst2=0.
3. Fill: four aligned pushes with no issue -> count=8, fetch_ready=0. A fifth fetch_valid is ignored (count stays 8). issue_cnt=1 -> count=7, fetch_ready still 0. issue_cnt=1 again -> fetch_ready=1.
4. Wrap-around: alternate aligned pushes and issue_cnt=2 for 10 cycles -> out_pc1/out_pc2 track fetch_pc and +4 exactly, with no reordering when rd_ptr=7 (slot 2 comes from entry 0).
5. Flush with count=5, fetch_valid=1 and issue_cnt=1 in the same cycle -> next cycle count=0, out_valid1=0, and the pushed packet is absent.
6. issue_cnt=2 with count=1 -> count=0, no underflow, rd_ptr advances by 1. Also: rst=0 asserted during a push (with flush=1 in the same cycle) -> all outputs at their reset values next cycle.
